tdm_demux4: RTL and testbench

//  Receive end of the 4-slot time-division link driven by the 4:1 MUX path.

---
 rtl/tdm_demux4.sv | 131 +++++++++++++
 tb/tb_tdm_demux4.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: rebuilds 4-lane frames from a serial word stream
// and tracks frame alignment with a HUNT/LOCK FSM that drops lock after repeated missing markers.
module tdm_demux4 #(
    parameter int WIDTH      = 4,
    parameter int MISS_LIMIT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     din,
    input  logic                 din_valid,
    input  logic                 frame_sync,
    output logic [4*WIDTH-1:0]   out_frame,
    output logic                 frame_valid,
    output logic [1:0]           slot,
    output logic                 locked,
    output logic                 sync_err
);

    localparam int CNT_W = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                      state, state_n;
    logic [1:0]                  slot_n;
    logic [CNT_W-1:0]            miss_cnt, miss_n, miss_inc;
    logic [2:0][WIDTH-1:0]       shadow, shadow_n;
    logic [4*WIDTH-1:0]          out_frame_n;
    logic                        frame_valid_n;
    logic                        sync_err_n;

    assign miss_inc = miss_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 2'd0;
            miss_cnt    <= '0;
            shadow      <= '0;
            out_frame   <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            miss_cnt    <= miss_n;
            shadow      <= shadow_n;
            out_frame   <= out_frame_n;
            frame_valid <= frame_valid_n;
            sync_err    <= sync_err_n;
        end
    end

    assign locked = (state == LOCK);

    // Every accepted word restarts the frame, extends it, completes it, or abandons alignment.
    always_comb begin
        state_n       = state;
        slot_n        = slot;
        miss_n        = miss_cnt;
        shadow_n      = shadow;
        out_frame_n   = out_frame;
        frame_valid_n = 1'b0;
        sync_err_n    = 1'b0;

        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_n[0] = din;
                        slot_n      = 2'd1;
                        miss_n      = '0;
                        state_n     = LOCK;
                    end
                end

                LOCK: begin
                    if (slot == 2'd0) begin
                        if (frame_sync) begin
                            shadow_n[0] = din;
                            slot_n      = 2'd1;
                            miss_n      = '0;
                        end else begin
                            sync_err_n = 1'b1;
                            if (miss_inc >= CNT_W'(MISS_LIMIT)) begin
                                state_n = HUNT;
                                slot_n  = 2'd0;
                                miss_n  = '0;
                            end else begin
                                shadow_n[0] = din;
                                slot_n      = 2'd1;
                                miss_n      = miss_inc;
                            end
                        end
                    end else if (frame_sync) begin
                        // Marker arrived early: treat this word as the new slot 0.
                        sync_err_n  = 1'b1;
                        shadow_n[0] = din;
                        slot_n      = 2'd1;
                        miss_n      = '0;
                    end else begin
                        case (slot)
                            2'd1: begin
                                shadow_n[1] = din;
                                slot_n      = 2'd2;
                            end
                            2'd2: begin
                                shadow_n[2] = din;
                                slot_n      = 2'd3;
                            end
                            default: begin
                                out_frame_n   = {din, shadow[2], shadow[1], shadow[0]};
                                frame_valid_n = 1'b1;
                                slot_n        = 2'd0;
                            end
                        endcase
                    end
                end

                default: begin
                    state_n = HUNT;
                    slot_n  = 2'd0;
                    miss_n  = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed, table-driven bench for tdm_demux4: each record is one cycle of input
// and the outputs expected just after the clock edge that consumes it.
module tb_tdm_demux4;

    logic        clk;
    logic        rst;
    logic [3:0]  din;
    logic        din_valid;
    logic        frame_sync;
    logic [15:0] out_frame;
    logic        frame_valid;
    logic [1:0]  slot;
    logic        locked;
    logic        sync_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic        s;
        logic [3:0]  d;
        logic        fv;
        logic [15:0] frame;
        logic        err;
        logic        lk;
        logic [1:0]  sl;
    } vec_t;

    vec_t vecs[$];

    tdm_demux4 #(.WIDTH(4), .MISS_LIMIT(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_sync  (frame_sync),
        .out_frame   (out_frame),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic v, input logic s, input logic [3:0] d, input logic fv,
                          input logic [15:0] f, input logic err, input logic lk, input logic [1:0] sl);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.fv = fv; t.frame = f; t.err = err; t.lk = lk; t.sl = sl;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t t, input int idx);
        @(negedge clk);
        din_valid  = t.v;
        frame_sync = t.s;
        din        = t.d;
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d frame_valid", idx), {15'd0, frame_valid}, {15'd0, t.fv});
        checkOutput($sformatf("vec%0d out_frame", idx), out_frame, t.frame);
        checkOutput($sformatf("vec%0d sync_err", idx), {15'd0, sync_err}, {15'd0, t.err});
        checkOutput($sformatf("vec%0d locked", idx), {15'd0, locked}, {15'd0, t.lk});
        checkOutput($sformatf("vec%0d slot", idx), {14'd0, slot}, {14'd0, t.sl});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " out_frame"}, out_frame, 16'h0000);
        checkOutput({tag, " frame_valid"}, {15'd0, frame_valid}, 16'h0000);
        checkOutput({tag, " slot"}, {14'd0, slot}, 16'h0000);
        checkOutput({tag, " locked"}, {15'd0, locked}, 16'h0000);
        checkOutput({tag, " sync_err"}, {15'd0, sync_err}, 16'h0000);
    endtask

    initial begin
        // Basic frame, back to back
        addVec(1, 1, 4'h1, 0, 16'h0000, 0, 1, 1);
        addVec(1, 0, 4'h4, 0, 16'h0000, 0, 1, 2);
        addVec(1, 0, 4'h5, 0, 16'h0000, 0, 1, 3);
        addVec(1, 0, 4'h3, 1, 16'h3541, 0, 1, 0);
        addVec(0, 0, 4'h0, 0, 16'h3541, 0, 1, 0);
        // Same frame with 3-cycle gaps; idle cycles carry junk that must be ignored
        addVec(1, 1, 4'h1, 0, 16'h3541, 0, 1, 1);
        for (int i = 0; i < 3; i++) addVec(0, 1, 4'hE, 0, 16'h3541, 0, 1, 1);
        addVec(1, 0, 4'h4, 0, 16'h3541, 0, 1, 2);
        for (int i = 0; i < 3; i++) addVec(0, 0, 4'hE, 0, 16'h3541, 0, 1, 2);
        addVec(1, 0, 4'h5, 0, 16'h3541, 0, 1, 3);
        for (int i = 0; i < 3; i++) addVec(0, 1, 4'hE, 0, 16'h3541, 0, 1, 3);
        addVec(1, 0, 4'h3, 1, 16'h3541, 0, 1, 0);
        addVec(0, 0, 4'h0, 0, 16'h3541, 0, 1, 0);
        // Slip: marker on the third word restarts the frame
        addVec(1, 1, 4'hA, 0, 16'h3541, 0, 1, 1);
        addVec(1, 0, 4'hC, 0, 16'h3541, 0, 1, 2);
        addVec(1, 1, 4'h8, 0, 16'h3541, 1, 1, 1);
        addVec(1, 0, 4'h1, 0, 16'h3541, 0, 1, 2);
        addVec(1, 0, 4'h2, 0, 16'h3541, 0, 1, 3);
        addVec(1, 0, 4'h3, 1, 16'h3218, 0, 1, 0);
        // Lost marker twice: first frame delivered, second miss drops lock
        addVec(1, 0, 4'h6, 0, 16'h3218, 1, 1, 1);
        addVec(1, 0, 4'h7, 0, 16'h3218, 0, 1, 2);
        addVec(1, 0, 4'h8, 0, 16'h3218, 0, 1, 3);
        addVec(1, 0, 4'h9, 1, 16'h9876, 0, 1, 0);
        addVec(1, 0, 4'h5, 0, 16'h9876, 1, 0, 0);
        // HUNT discards unmarked words and ignores markers on idle cycles
        for (int i = 0; i < 5; i++) addVec(1, 0, 4'(i + 2), 0, 16'h9876, 0, 0, 0);
        addVec(0, 1, 4'hF, 0, 16'h9876, 0, 0, 0);
        addVec(1, 1, 4'hF, 0, 16'h9876, 0, 1, 1);
        addVec(1, 0, 4'h0, 0, 16'h9876, 0, 1, 2);
        addVec(1, 0, 4'hF, 0, 16'h9876, 0, 1, 3);
        addVec(1, 0, 4'h0, 1, 16'h0F0F, 0, 1, 0);
        // Miss, good marker, miss: the good marker clears the miss count so lock holds
        addVec(1, 0, 4'h1, 0, 16'h0F0F, 1, 1, 1);
        addVec(1, 0, 4'h2, 0, 16'h0F0F, 0, 1, 2);
        addVec(1, 0, 4'h3, 0, 16'h0F0F, 0, 1, 3);
        addVec(1, 0, 4'h4, 1, 16'h4321, 0, 1, 0);
        addVec(1, 1, 4'h5, 0, 16'h4321, 0, 1, 1);
        addVec(1, 0, 4'h6, 0, 16'h4321, 0, 1, 2);
        addVec(1, 0, 4'h7, 0, 16'h4321, 0, 1, 3);
        addVec(1, 0, 4'h8, 1, 16'h8765, 0, 1, 0);
        addVec(1, 0, 4'h9, 0, 16'h8765, 1, 1, 1);
        addVec(1, 0, 4'hA, 0, 16'h8765, 0, 1, 2);
        addVec(1, 0, 4'hB, 0, 16'h8765, 0, 1, 3);
        addVec(1, 0, 4'hC, 1, 16'hCBA9, 0, 1, 0);

        din        = 4'h0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        rst        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Reset asserted while frame_valid is high must clear everything before the next edge
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        rst = 1'b0;

        // After reset the bench is back in HUNT; a partial marked frame then reset loses it
        begin
            vec_t t;
            t.v = 1; t.s = 1; t.d = 4'h7; t.fv = 0; t.frame = 16'h0000; t.err = 0; t.lk = 1; t.sl = 1;
            applyStimulus(t, 900);
            t.v = 1; t.s = 0; t.d = 4'h6; t.fv = 0; t.frame = 16'h0000; t.err = 0; t.lk = 1; t.sl = 2;
            applyStimulus(t, 901);
        end
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("partialreset");
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t t;
            t.v = 1; t.s = 0; t.d = 4'h5; t.fv = 0; t.frame = 16'h0000; t.err = 0; t.lk = 0; t.sl = 0;
            applyStimulus(t, 902);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
